subleq_core: RTL and testbench

- Multi-cycle SUBLEQ sequencer: mem[B] <= mem[B] - mem[A]; if the result is <= 0, jump to C, else PC advances by 3.
- Sits downstream of the gate-level logic stage. It is the sequential controller that consumes the combinational result and flag logic and adds the clocked state: program counter, operand registers and a small word memory.
- A host loads a program while the core is idle, pulses start, and observes the busy and halted status.

---
 rtl/subleq_pkg.sv | 18 +
 rtl/subleq_alu.sv | 17 +
 rtl/subleq_core.sv | 131 +++++++++++++
 tb/tb_subleq_core.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared types and default sizing for the SUBLEQ core.
// Imported by the core and the ALU.
package subleq_pkg;

  localparam int WORD_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam logic [3:0] HALT_ADDR_DEF = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    FETCH_C,
    EXEC,
    HALT
  } state_t;

endpackage

// File: rtl/subleq_alu.sv
// Combinational subtract and branch flag for SUBLEQ.
// res = b - a, truncated; le when res is negative or zero.
module subleq_alu
  import subleq_pkg::*;
#(
  parameter int W = WORD_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         le
);

  assign res = b - a;
  assign le  = res[W-1] | (res == '0);

endmodule

// File: rtl/subleq_core.sv
// Multi-cycle SUBLEQ sequencer with a small word memory.
// Host loads while idle, pulses start, watches busy/halted.
module subleq_core
  import subleq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic              le_flag
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [WORD_W-1:0] ra, rb, rc;
  logic [WORD_W-1:0] ra_d, rb_d, rc_d;
  logic le_d;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WORD_W-1:0] wd;

  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [WORD_W-1:0] res;
  logic              le;

  // Operand words address memory through their low bits.
  assign a_addr = ra[ADDR_W-1:0];
  assign b_addr = rb[ADDR_W-1:0];
  assign c_addr = rc[ADDR_W-1:0];

  assign busy = (state_q == FETCH_A) || (state_q == FETCH_B)
             || (state_q == FETCH_C) || (state_q == EXEC);
  assign halted  = (state_q == HALT);
  assign rd_data = mem[rd_addr];

  subleq_alu #(.W(WORD_W)) u_alu (
    .a   (mem[a_addr]),
    .b   (mem[b_addr]),
    .res (res),
    .le  (le)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    ra_d    = ra;
    rb_d    = rb;
    rc_d    = rc;
    le_d    = le_flag;
    we      = load_en && !busy;
    wa      = load_addr;
    wd      = load_data;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = FETCH_A;
          pc_d    = '0;
        end
      end
      FETCH_A: begin
        ra_d    = mem[pc];
        state_d = FETCH_B;
      end
      FETCH_B: begin
        rb_d    = mem[pc + ADDR_W'(1)];
        state_d = FETCH_C;
      end
      FETCH_C: begin
        rc_d    = mem[pc + ADDR_W'(2)];
        state_d = EXEC;
      end
      EXEC: begin
        we   = 1'b1;
        wa   = b_addr;
        wd   = res;
        le_d = le;
        if (le && c_addr == HALT_ADDR) begin
          state_d = HALT;
          pc_d    = HALT_ADDR;
        end else if (le) begin
          state_d = FETCH_A;
          pc_d    = c_addr;
        end else begin
          state_d = FETCH_A;
          pc_d    = pc + ADDR_W'(3);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc      <= '0;
      ra      <= '0;
      rb      <= '0;
      rc      <= '0;
      le_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      ra      <= ra_d;
      rb      <= rb_d;
      rc      <= rc_d;
      le_flag <= le_d;
    end
  end

  // Memory keeps its contents through reset; rst only blocks writes.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wa] <= wd;
  end

endmodule

// File: tb/tb_subleq_core.sv
// Directed self-checking bench for subleq_core.
// Each task runs one scenario with inline checks.
module tb_subleq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [3:0] load_data = '0;
  logic [3:0] rd_addr = '0;
  logic [3:0] rd_data;
  logic       busy;
  logic       halted;
  logic [3:0] pc;
  logic       le_flag;

  int n_vec = 0;
  int n_err = 0;

  subleq_core dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .halted    (halted),
    .pc        (pc),
    .le_flag   (le_flag)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick(1);
    load_en = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [3:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] v;
    for (int i = 0; i < 16; i++) load(4'(i), 4'd0);
    load(4'd5, 4'd9);
    pulse_start();
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    peek(4'd5, v);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_busy got %b want 0", busy);
    end
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL rst_halted got %b want 0", halted);
    end
    n_vec++;
    if (pc !== 4'd0) begin
      n_err++; $display("FAIL rst_pc got %0d want 0", pc);
    end
    n_vec++;
    if (le_flag !== 1'b0) begin
      n_err++; $display("FAIL rst_le got %b want 0", le_flag);
    end
    n_vec++;
    if (v !== 4'd9) begin
      n_err++; $display("FAIL rst_mem5 got %0d want 9", v);
    end
  endtask

  task automatic test_two_instr();
    logic [3:0] v;
    logic [3:0] prog [6] = '{4'd13, 4'd14, 4'd15, 4'd14, 4'd14, 4'd15};
    pulse_rst();
    for (int i = 0; i < 6; i++) load(4'(i), prog[i]);
    load(4'd13, 4'd3);
    load(4'd14, 4'd5);
    pulse_start();
    tick(4);
    peek(4'd14, v);
    n_vec++;
    if (v !== 4'd2) begin
      n_err++; $display("FAIL p1_mem14 got %0d want 2", v);
    end
    n_vec++;
    if (le_flag !== 1'b0) begin
      n_err++; $display("FAIL p1_le got %b want 0", le_flag);
    end
    n_vec++;
    if (pc !== 4'd3) begin
      n_err++; $display("FAIL p1_pc got %0d want 3", pc);
    end
    tick(4);
    peek(4'd14, v);
    n_vec++;
    if (v !== 4'd0) begin
      n_err++; $display("FAIL p2_mem14 got %0d want 0", v);
    end
    n_vec++;
    if (le_flag !== 1'b1) begin
      n_err++; $display("FAIL p2_le got %b want 1", le_flag);
    end
    n_vec++;
    if (halted !== 1'b1) begin
      n_err++; $display("FAIL p2_halted got %b want 1", halted);
    end
    n_vec++;
    if (pc !== 4'd15) begin
      n_err++; $display("FAIL p2_pc got %0d want 15", pc);
    end
  endtask

  task automatic test_taken();
    logic [3:0] v;
    pulse_rst();
    load(4'd0, 4'd10);
    load(4'd1, 4'd11);
    load(4'd2, 4'd6);
    load(4'd10, 4'd4);
    load(4'd11, 4'd4);
    pulse_start();
    tick(4);
    peek(4'd11, v);
    n_vec++;
    if (v !== 4'd0) begin
      n_err++; $display("FAIL tk_mem11 got %0d want 0", v);
    end
    n_vec++;
    if (pc !== 4'd6) begin
      n_err++; $display("FAIL tk_pc got %0d want 6", pc);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL tk_busy got %b want 1", busy);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    logic [3:0] addr [10] = '{0, 1, 2, 3, 4, 5, 9, 12, 14, 15};
    logic [3:0] data [10] = '{9, 1, 8, 12, 12, 14, 0, 5, 1, 2};
    pulse_rst();
    for (int i = 0; i < 10; i++) load(addr[i], data[i]);
    pulse_start();
    tick(8);
    n_vec++;
    if (pc !== 4'd14) begin
      n_err++; $display("FAIL wr_pc14 got %0d want 14", pc);
    end
    n_vec++;
    if (le_flag !== 1'b1) begin
      n_err++; $display("FAIL wr_le1 got %b want 1", le_flag);
    end
    tick(4);
    peek(4'd2, v);
    n_vec++;
    if (v !== 4'd7) begin
      n_err++; $display("FAIL wr_mem2 got %0d want 7", v);
    end
    n_vec++;
    if (le_flag !== 1'b0) begin
      n_err++; $display("FAIL wr_le0 got %b want 0", le_flag);
    end
    n_vec++;
    if (pc !== 4'd1) begin
      n_err++; $display("FAIL wr_pc1 got %0d want 1", pc);
    end
  endtask

  task automatic test_protocol();
    logic [3:0] v;
    logic [3:0] prog [6] = '{4'd13, 4'd14, 4'd15, 4'd14, 4'd14, 4'd15};
    pulse_rst();
    for (int i = 0; i < 6; i++) load(4'(i), prog[i]);
    load(4'd13, 4'd3);
    load(4'd14, 4'd5);
    pulse_start();
    load_en   = 1'b1;
    load_addr = 4'd13;
    load_data = 4'd7;
    start     = 1'b1;
    tick(2);
    load_en = 1'b0;
    start   = 1'b0;
    tick(2);
    peek(4'd14, v);
    n_vec++;
    if (pc !== 4'd3) begin
      n_err++; $display("FAIL pr_pc3 got %0d want 3", pc);
    end
    n_vec++;
    if (v !== 4'd2) begin
      n_err++; $display("FAIL pr_mem14 got %0d want 2", v);
    end
    tick(4);
    peek(4'd13, v);
    n_vec++;
    if (v !== 4'd3) begin
      n_err++; $display("FAIL pr_mem13 got %0d want 3", v);
    end
    n_vec++;
    if (halted !== 1'b1 || pc !== 4'd15) begin
      n_err++; $display("FAIL pr_halt got h=%b pc=%0d want h=1 pc=15", halted, pc);
    end
    pulse_start();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL pr_rs_busy got %b want 1", busy);
    end
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++; $display("FAIL pr_rs_halted got %b want 0", halted);
    end
    n_vec++;
    if (pc !== 4'd0) begin
      n_err++; $display("FAIL pr_rs_pc got %0d want 0", pc);
    end
  endtask

  task automatic test_exec_reset();
    logic [3:0] v;
    pulse_rst();
    load(4'd0, 4'd10);
    load(4'd1, 4'd11);
    load(4'd10, 4'd1);
    load(4'd11, 4'd6);
    load_en   = 1'b1;
    load_addr = 4'd2;
    load_data = 4'd15;
    start     = 1'b1;
    tick(1);
    load_en = 1'b0;
    start   = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL er_start got %b want 1", busy);
    end
    tick(3);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL er_exec_busy got %b want 1", busy);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    peek(4'd11, v);
    n_vec++;
    if (v !== 4'd6) begin
      n_err++; $display("FAIL er_mem11 got %0d want 6", v);
    end
    n_vec++;
    if (busy !== 1'b0 || halted !== 1'b0 || pc !== 4'd0) begin
      n_err++; $display("FAIL er_idle got b=%b h=%b pc=%0d want 0 0 0", busy, halted, pc);
    end
    peek(4'd2, v);
    n_vec++;
    if (v !== 4'd15) begin
      n_err++; $display("FAIL er_mem2 got %0d want 15", v);
    end
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    test_reset();
    test_two_instr();
    test_taken();
    test_wrap();
    test_protocol();
    test_exec_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
